reset_sequencer: RTL

Parametrised power-on and push-button reset controller for the SoC top. It replaces the ad-hoc init/debounce/start FSM and the single-output reset synchroniser. The block debounces the external reset button, waits for all PLL locks to be stable, and releases NUM_DOMAINS active-low resets in order with a fixed gap. It also provides a run/single-step CPU clock enable.

---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/debounce_sync.sv | 48 ++++
 rtl/reset_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared FSM encoding and limits for the reset sequencer and its helpers.
// Combinational constants only; no latency or backpressure.
package reset_seq_pkg;

   localparam int STATE_W         = 3;
   localparam int RESET_COUNT_MAX = 255;

   typedef enum logic [STATE_W-1:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus stable-level filter: the output follows the input only
// after DEBOUNCE_CYCLES steady cycles (2 sync + DEBOUNCE_CYCLES latency); no backpressure.
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 65535,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
   input  logic clk,
   input  logic resetn,
   input  logic din,
   output logic dout
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             dout_q, dout_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle where the synchronised level matches the accepted one restarts the count.
   always_comb begin
      dout_d = dout_q;
      cnt_d  = '0;
      if (sync2_q != dout_q) begin
         if (cnt_q == CNT_LAST) begin
            dout_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= din;
         sync2_q <= sync1_q;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = dout_q;

endmodule

// File: rtl/reset_sequencer.sv
// Debounces the reset button, waits for stable PLL locks, then releases domain resets
// in order with a fixed gap; registered outputs, free-running, no backpressure.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS        = 4,
   parameter int NUM_LOCKS          = 1,
   parameter int DEBOUNCE_CYCLES    = 65535,
   parameter int LOCK_STABLE_CYCLES = 256,
   parameter int RELEASE_GAP        = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   ext_reset_n,
   input  logic [NUM_LOCKS-1:0]   locks,
   input  logic                   step_mode,
   input  logic                   step_btn,
   output logic [NUM_DOMAINS-1:0] domain_reset_n,
   output logic                   cpu_clk_en,
   output logic                   all_released,
   output logic [STATE_W-1:0]     state_out,
   output logic [7:0]             reset_count
);

   localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, LOCK_STABLE_CYCLES, RELEASE_GAP)) + 1;
   localparam int IDX_W = $clog2(NUM_DOMAINS) + 1;

   localparam logic [CNT_W-1:0]       LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
   localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
   localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);
   localparam logic [7:0]             RC_MAX    = 8'(RESET_COUNT_MAX);

   logic                   ext_db, step_db;
   logic [NUM_LOCKS-1:0]   locks_s1_q, locks_s2_q;
   logic                   mode_s1_q, mode_s2_q;
   logic                   step_prev_q, step_pulse, locks_ok, abort;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [NUM_DOMAINS-1:0] dom_q, dom_d;
   logic                   cpu_en_q, cpu_en_d;
   logic                   all_rel_q, all_rel_d;
   logic [7:0]             rcount_q, rcount_d;

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_ext (
      .clk    (clk),
      .resetn (resetn),
      .din    (ext_reset_n),
      .dout   (ext_db)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_step (
      .clk    (clk),
      .resetn (resetn),
      .din    (step_btn),
      .dout   (step_db)
   );

   assign locks_ok   = &locks_s2_q;
   assign step_pulse = step_db & ~step_prev_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      dom_d    = dom_q;
      rcount_d = rcount_q;
      abort    = 1'b0;
      case (state_q)
         HOLD: begin
            cnt_d = '0;
            idx_d = '0;
            dom_d = '0;
            if (ext_db) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // A lock drop here only restarts the stability window.
            if (!ext_db) begin
               abort = 1'b1;
            end else if (!locks_ok) begin
               cnt_d = '0;
            end else if (cnt_q == LOCK_LAST) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
               dom_d   = DOM_ONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RELEASE: begin
            if (!ext_db || !locks_ok) begin
               abort = 1'b1;
            end else if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = RUN;
               end else begin
                  idx_d = idx_q + 1'b1;
                  dom_d = dom_q | (DOM_ONE << idx_d);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN: begin
            if (!ext_db || !locks_ok) abort = 1'b1;
         end
         default: state_d = HOLD;
      endcase

      // Abort overrides whatever release step was decided above.
      if (abort) begin
         state_d = HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         dom_d   = '0;
         if (rcount_q != RC_MAX) rcount_d = rcount_q + 1'b1;
      end

      all_rel_d = (state_d == RUN);
      cpu_en_d  = (state_d == RUN) && (!mode_s2_q || step_pulse);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         locks_s1_q  <= '0;
         locks_s2_q  <= '0;
         mode_s1_q   <= 1'b0;
         mode_s2_q   <= 1'b0;
         step_prev_q <= 1'b0;
         state_q     <= HOLD;
         cnt_q       <= '0;
         idx_q       <= '0;
         dom_q       <= '0;
         cpu_en_q    <= 1'b0;
         all_rel_q   <= 1'b0;
         rcount_q    <= '0;
      end else begin
         locks_s1_q  <= locks;
         locks_s2_q  <= locks_s1_q;
         mode_s1_q   <= step_mode;
         mode_s2_q   <= mode_s1_q;
         step_prev_q <= step_db;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         dom_q       <= dom_d;
         cpu_en_q    <= cpu_en_d;
         all_rel_q   <= all_rel_d;
         rcount_q    <= rcount_d;
      end
   end

   assign domain_reset_n = dom_q;
   assign cpu_clk_en     = cpu_en_q;
   assign all_released   = all_rel_q;
   assign state_out      = state_q;
   assign reset_count    = rcount_q;

endmodule
